// File: rtl/cva6_shared_tlb_ptw_sv32.sv
// Sv32 page-table walker for the shared TLB: walks the two-level table on a miss
// and returns a leaf refill or a one-cycle page-fault pulse.
// Ports:
//   clk_i, rst_ni          clock, async active-low reset
//   flush_i                abort walk, suppress refill
//   satp_ppn_i, asid_i     root table PPN, current ASID
//   shared_tlb_*_i         lookup, hit and VA from the shared TLB
//   itlb_req_i             lookup came from the ITLB
//   shared_tlb_update_o    refill bundle
//   ptw_active_o           walker busy
//   walking_instr_o        walk is for instruction fetch
//   ptw_error_o            page-fault pulse
//   ptw_bad_vaddr_o        faulting VA
//   mem_*                  single-outstanding PTE read port

package cva6_shared_tlb_ptw_sv32_pkg;

  typedef struct packed {
    logic [21:0] ppn;
    logic [1:0]  rsw;
    logic        d;
    logic        a;
    logic        g;
    logic        u;
    logic        x;
    logic        w;
    logic        r;
    logic        v;
  } pte_sv32_t;

  // asid is sized for the largest Sv32 ASID; narrower ASIDs are zero-extended
  typedef struct packed {
    logic        valid;
    logic        is_4M;
    logic [19:0] vpn;
    logic [8:0]  asid;
    pte_sv32_t   content;
  } tlb_update_sv32_t;

endpackage

module cva6_shared_tlb_ptw_sv32
  import cva6_shared_tlb_ptw_sv32_pkg::*;
#(
  parameter int unsigned ASID_WIDTH = 1,
  parameter int unsigned PLEN       = 34
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  flush_i,
  input  logic [21:0]           satp_ppn_i,
  input  logic [ASID_WIDTH-1:0] asid_i,
  input  logic                  shared_tlb_access_i,
  input  logic                  shared_tlb_hit_i,
  input  logic [31:0]           shared_tlb_vaddr_i,
  input  logic                  itlb_req_i,
  output tlb_update_sv32_t      shared_tlb_update_o,
  output logic                  ptw_active_o,
  output logic                  walking_instr_o,
  output logic                  ptw_error_o,
  output logic [31:0]           ptw_bad_vaddr_o,
  output logic                  mem_req_o,
  output logic [PLEN-1:0]       mem_addr_o,
  input  logic                  mem_gnt_i,
  input  logic                  mem_rvalid_i,
  input  logic [31:0]           mem_rdata_i
);

  typedef enum logic [2:0] {
    IDLE,
    WAIT_GRANT,
    PTE_LOOKUP,
    PROPAGATE_ERROR,
    WAIT_RVALID
  } state_e;

  state_e                state_q;
  logic [31:0]           vaddr_q;
  logic [ASID_WIDTH-1:0] asid_q;
  logic                  level_q;

  pte_sv32_t       pte;
  logic            bad_pte;
  logic            is_leaf;
  logic            leaf_ok;
  logic            next_lvl;
  logic [PLEN-1:0] root_addr;
  logic [PLEN-1:0] l0_addr;

  // Exclusive decode of the returned PTE; anything not a good leaf
  // or a level-1 pointer is a fault.
  always_comb begin
    pte       = pte_sv32_t'(mem_rdata_i);
    bad_pte   = ~pte.v | (~pte.r & pte.w);
    is_leaf   = ~bad_pte & (pte.r | pte.x);
    leaf_ok   = is_leaf & pte.a
              & ~(level_q & (pte.ppn[9:0] != 10'd0));
    next_lvl  = ~bad_pte & ~(pte.r | pte.x) & level_q;
    root_addr = PLEN'({satp_ppn_i, 12'b0})
              + PLEN'({shared_tlb_vaddr_i[31:22], 2'b00});
    l0_addr   = PLEN'({pte.ppn, 12'b0})
              + PLEN'({vaddr_q[21:12], 2'b00});
  end

  assign ptw_active_o = (state_q != IDLE);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q             <= IDLE;
      vaddr_q             <= '0;
      asid_q              <= '0;
      level_q             <= 1'b0;
      shared_tlb_update_o <= '0;
      walking_instr_o     <= 1'b0;
      ptw_error_o         <= 1'b0;
      ptw_bad_vaddr_o     <= '0;
      mem_req_o           <= 1'b0;
      mem_addr_o          <= '0;
    end else begin
      shared_tlb_update_o.valid <= 1'b0;
      ptw_error_o               <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (shared_tlb_access_i & ~shared_tlb_hit_i & ~flush_i) begin
            vaddr_q         <= shared_tlb_vaddr_i;
            asid_q          <= asid_i;
            walking_instr_o <= itlb_req_i;
            level_q         <= 1'b1;
            mem_addr_o      <= root_addr;
            mem_req_o       <= 1'b1;
            state_q         <= WAIT_GRANT;
          end
        end
        WAIT_GRANT: begin
          if (mem_gnt_i) begin
            mem_req_o <= 1'b0;
            state_q   <= flush_i ? WAIT_RVALID : PTE_LOOKUP;
          end else if (flush_i) begin
            mem_req_o <= 1'b0;
            state_q   <= IDLE;
          end
        end
        PTE_LOOKUP: begin
          if (flush_i) begin
            state_q <= mem_rvalid_i ? IDLE : WAIT_RVALID;
          end else if (mem_rvalid_i) begin
            unique case (1'b1)
              leaf_ok: begin
                shared_tlb_update_o.valid   <= 1'b1;
                shared_tlb_update_o.is_4M   <= level_q;
                shared_tlb_update_o.vpn     <= vaddr_q[31:12];
                shared_tlb_update_o.asid    <= 9'(asid_q);
                shared_tlb_update_o.content <= pte;
                state_q                     <= IDLE;
              end
              next_lvl: begin
                level_q    <= 1'b0;
                mem_addr_o <= l0_addr;
                mem_req_o  <= 1'b1;
                state_q    <= WAIT_GRANT;
              end
              default: begin
                ptw_error_o     <= 1'b1;
                ptw_bad_vaddr_o <= vaddr_q;
                state_q         <= PROPAGATE_ERROR;
              end
            endcase
          end
        end
        PROPAGATE_ERROR: begin
          state_q <= IDLE;
        end
        WAIT_RVALID: begin
          if (mem_rvalid_i) state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_cva6_shared_tlb_ptw_sv32.sv
// Scoreboard bench for the Sv32 shared-TLB page-table walker.
// Directed walks; a memory model and an output monitor check against queues.

module tb_cva6_shared_tlb_ptw_sv32;
  import cva6_shared_tlb_ptw_sv32_pkg::*;

  logic             clk_i = 1'b0;
  logic             rst_ni = 1'b0;
  logic             flush_i = 1'b0;
  logic [21:0]      satp_ppn_i = 22'h80000;
  logic [0:0]       asid_i = 1'b1;
  logic             shared_tlb_access_i = 1'b0;
  logic             shared_tlb_hit_i = 1'b0;
  logic [31:0]      shared_tlb_vaddr_i = '0;
  logic             itlb_req_i = 1'b0;
  tlb_update_sv32_t shared_tlb_update_o;
  logic             ptw_active_o;
  logic             walking_instr_o;
  logic             ptw_error_o;
  logic [31:0]      ptw_bad_vaddr_o;
  logic             mem_req_o;
  logic [33:0]      mem_addr_o;
  logic             mem_gnt_i = 1'b0;
  logic             mem_rvalid_i = 1'b0;
  logic [31:0]      mem_rdata_i = '0;

  cva6_shared_tlb_ptw_sv32 #(
    .ASID_WIDTH(1),
    .PLEN(34)
  ) dut (
    .clk_i(clk_i),
    .rst_ni(rst_ni),
    .flush_i(flush_i),
    .satp_ppn_i(satp_ppn_i),
    .asid_i(asid_i),
    .shared_tlb_access_i(shared_tlb_access_i),
    .shared_tlb_hit_i(shared_tlb_hit_i),
    .shared_tlb_vaddr_i(shared_tlb_vaddr_i),
    .itlb_req_i(itlb_req_i),
    .shared_tlb_update_o(shared_tlb_update_o),
    .ptw_active_o(ptw_active_o),
    .walking_instr_o(walking_instr_o),
    .ptw_error_o(ptw_error_o),
    .ptw_bad_vaddr_o(ptw_bad_vaddr_o),
    .mem_req_o(mem_req_o),
    .mem_addr_o(mem_addr_o),
    .mem_gnt_i(mem_gnt_i),
    .mem_rvalid_i(mem_rvalid_i),
    .mem_rdata_i(mem_rdata_i)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic        err;
    logic        is4m;
    logic [19:0] vpn;
    logic [31:0] content;
    logic [31:0] bad;
    logic        instr;
    logic        asid;
  } exp_t;

  exp_t        exp_q[$];
  logic [33:0] addr_q[$];
  logic [31:0] pte_q[$];
  int          gnt_dly = 0;
  int          rv_dly = 1;
  int          nvec = 0;
  int          nfail = 0;

  task automatic push_refill(input logic is4m, input logic [19:0] vpn,
                             input logic [31:0] c, input logic instr,
                             input logic asid);
    exp_t e;
    e.err = 1'b0; e.is4m = is4m; e.vpn = vpn; e.content = c;
    e.bad = '0; e.instr = instr; e.asid = asid;
    exp_q.push_back(e);
  endtask

  task automatic push_err(input logic [31:0] bad, input logic instr);
    exp_t e;
    e.err = 1'b1; e.is4m = 1'b0; e.vpn = '0; e.content = '0;
    e.bad = bad; e.instr = instr; e.asid = 1'b0;
    exp_q.push_back(e);
  endtask

  task automatic chk(input string name, input logic [33:0] act,
                     input logic [33:0] req);
    nvec++;
    if (act !== req) begin
      nfail++;
      $display("FAIL %s: got %h want %h", name, act, req);
    end
  endtask

  // Output monitor: every refill or error pulse must match the queue head.
  initial begin
    exp_t e;
    logic ok;
    forever begin
      @(negedge clk_i);
      if (shared_tlb_update_o.valid || ptw_error_o) begin
        nvec++;
        if (exp_q.size() == 0) begin
          nfail++;
          $display("FAIL unexpected_out: valid=%b err=%b vpn=%h bad=%h",
                   shared_tlb_update_o.valid, ptw_error_o,
                   shared_tlb_update_o.vpn, ptw_bad_vaddr_o);
        end else begin
          e = exp_q.pop_front();
          if (e.err)
            ok = ptw_error_o && !shared_tlb_update_o.valid
              && ptw_bad_vaddr_o == e.bad && walking_instr_o == e.instr;
          else
            ok = shared_tlb_update_o.valid && !ptw_error_o
              && shared_tlb_update_o.is_4M == e.is4m
              && shared_tlb_update_o.vpn == e.vpn
              && shared_tlb_update_o.content == e.content
              && shared_tlb_update_o.asid == {8'd0, e.asid}
              && walking_instr_o == e.instr;
          if (!ok) begin
            nfail++;
            $display({"FAIL out: got v=%b e=%b 4M=%b vpn=%h as=%h c=%h bad=%h i=%b",
                      " want e=%b 4M=%b vpn=%h as=%b c=%h bad=%h i=%b"},
                     shared_tlb_update_o.valid, ptw_error_o,
                     shared_tlb_update_o.is_4M, shared_tlb_update_o.vpn,
                     shared_tlb_update_o.asid, shared_tlb_update_o.content,
                     ptw_bad_vaddr_o, walking_instr_o, e.err, e.is4m,
                     e.vpn, e.asid, e.content, e.bad, e.instr);
          end
        end
      end
    end
  end

  // Memory model: checks each request address, holds off grant, returns PTE.
  initial begin
    logic [33:0] a;
    forever begin
      @(negedge clk_i);
      if (mem_req_o) begin
        a = mem_addr_o;
        if (addr_q.size() == 0) chk("unexpected_req", a, '1);
        else chk("mem_addr", a, addr_q.pop_front());
        for (int i = 0; i < gnt_dly; i++) begin
          @(negedge clk_i);
          chk("addr_stable", {mem_req_o, mem_addr_o}, {1'b1, a});
        end
        mem_gnt_i = 1'b1;
        @(negedge clk_i);
        mem_gnt_i = 1'b0;
        for (int i = 1; i < rv_dly; i++) @(negedge clk_i);
        mem_rvalid_i = 1'b1;
        if (pte_q.size() == 0) begin
          chk("pte_underflow", 34'd1, 34'd0);
          mem_rdata_i = '0;
        end else begin
          mem_rdata_i = pte_q.pop_front();
        end
        @(negedge clk_i);
        mem_rvalid_i = 1'b0;
      end
    end
  end

  task automatic miss(input logic [31:0] va, input logic itlb);
    @(negedge clk_i);
    shared_tlb_access_i = 1'b1;
    shared_tlb_hit_i    = 1'b0;
    shared_tlb_vaddr_i  = va;
    itlb_req_i          = itlb;
    @(negedge clk_i);
    shared_tlb_access_i = 1'b0;
    itlb_req_i          = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    while (ptw_active_o && n < 200) begin
      @(negedge clk_i);
      n++;
    end
    chk("idle_timeout", 34'(n >= 200), 34'd0);
    repeat (10) @(negedge clk_i);
  endtask

  task automatic walk(input logic [31:0] va, input logic itlb);
    miss(va, itlb);
    wait_idle();
  endtask

  initial begin
    repeat (3) @(negedge clk_i);
    chk("rst_active", 34'(ptw_active_o), 34'd0);
    chk("rst_req", 34'(mem_req_o), 34'd0);
    chk("rst_addr", mem_addr_o, 34'd0);
    chk("rst_upd", 34'(shared_tlb_update_o.valid), 34'd0);
    chk("rst_err", 34'(ptw_error_o), 34'd0);
    chk("rst_bad", 34'(ptw_bad_vaddr_o), 34'd0);
    rst_ni = 1'b1;

    // 4M leaf
    addr_q.push_back(34'h80000400); pte_q.push_back(32'h200000CF);
    push_refill(1'b1, 20'h40001, 32'h200000CF, 1'b1, 1'b1);
    walk(32'h40001000, 1'b1);

    // 4K two-level walk
    addr_q.push_back(34'h80000004); pte_q.push_back(32'h20000001);
    addr_q.push_back(34'h80000004); pte_q.push_back(32'h200001CF);
    push_refill(1'b0, 20'h00401, 32'h200001CF, 1'b0, 1'b1);
    walk(32'h00401000, 1'b0);

    // invalid PTE
    addr_q.push_back(34'h80000120); pte_q.push_back(32'h00000000);
    push_err(32'h12345000, 1'b0);
    walk(32'h12345000, 1'b0);

    // misaligned superpage
    addr_q.push_back(34'h80000400); pte_q.push_back(32'h200004CF);
    push_err(32'h40001000, 1'b1);
    walk(32'h40001000, 1'b1);

    // non-leaf at level 0
    addr_q.push_back(34'h80000004); pte_q.push_back(32'h20000001);
    addr_q.push_back(34'h80000004); pte_q.push_back(32'h20000001);
    push_err(32'h00401000, 1'b0);
    walk(32'h00401000, 1'b0);

    // A bit clear
    addr_q.push_back(34'h80000400); pte_q.push_back(32'h2000000F);
    push_err(32'h40001000, 1'b0);
    walk(32'h40001000, 1'b0);

    // write without read
    addr_q.push_back(34'h80000400); pte_q.push_back(32'h20000005);
    push_err(32'h40001000, 1'b0);
    walk(32'h40001000, 1'b0);

    // other root, top VPN, asid 0, slow rvalid
    satp_ppn_i = 22'h00123; asid_i = 1'b0; rv_dly = 3;
    addr_q.push_back(34'h00123FFC); pte_q.push_back(32'h00048001);
    addr_q.push_back(34'h0012000C); pte_q.push_back(32'h0004A0CB);
    push_refill(1'b0, 20'hFFC03, 32'h0004A0CB, 1'b1, 1'b0);
    walk(32'hFFC03ABC, 1'b1);
    satp_ppn_i = 22'h80000; asid_i = 1'b1; rv_dly = 1;

    // delayed grant plus a dropped miss while busy
    gnt_dly = 5;
    addr_q.push_back(34'h80000400); pte_q.push_back(32'h200000CF);
    push_refill(1'b1, 20'h40001, 32'h200000CF, 1'b0, 1'b1);
    miss(32'h40001000, 1'b0);
    miss(32'h12345000, 1'b1);
    wait_idle();
    gnt_dly = 0;

    // hit keeps the walker idle
    @(negedge clk_i);
    shared_tlb_access_i = 1'b1; shared_tlb_hit_i = 1'b1;
    shared_tlb_vaddr_i = 32'h40001000;
    @(negedge clk_i);
    shared_tlb_access_i = 1'b0; shared_tlb_hit_i = 1'b0;
    chk("hit_idle", 34'({ptw_active_o, mem_req_o}), 34'd0);

    // flush while waiting for rvalid
    rv_dly = 4;
    addr_q.push_back(34'h80000400); pte_q.push_back(32'h200000CF);
    miss(32'h40001000, 1'b0);
    @(negedge clk_i);
    flush_i = 1'b1;
    @(negedge clk_i);
    flush_i = 1'b0;
    chk("flush_busy", 34'(ptw_active_o), 34'd1);
    wait_idle();
    chk("flush_idle", 34'(ptw_active_o), 34'd0);

    // reset mid-walk, late rvalid ignored
    rv_dly = 3;
    addr_q.push_back(34'h80000400); pte_q.push_back(32'h200000CF);
    miss(32'h40001000, 1'b0);
    @(negedge clk_i);
    rst_ni = 1'b0;
    #1;
    chk("rst_mid_active", 34'(ptw_active_o), 34'd0);
    chk("rst_mid_req", 34'(mem_req_o), 34'd0);
    @(negedge clk_i);
    rst_ni = 1'b1;
    repeat (10) @(negedge clk_i);
    chk("rst_mid_idle", 34'(ptw_active_o), 34'd0);
    rv_dly = 1;

    chk("exp_left", 34'(exp_q.size()), 34'd0);
    chk("addr_left", 34'(addr_q.size()), 34'd0);
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

endmodule
